// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunk-serial wide adder.
// Holds the controller state encoding and the operand width derivation.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int total_width(input int chunk_width, input int num_chunks);
        return chunk_width * num_chunks;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_cr_adder.sv
// Narrow combinational carry-ripple adder used once per cycle by seq_chunk_adder.
// One full-adder cell per bit, carry rippling from bit 0 upward.
module cr_adder #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             c_in,
    output logic [Width-1:0] sum,
    output logic             c_out
);

    logic [Width:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < Width; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[Width];

endmodule

// File: rtl/seq_chunk_adder.sv
// Wide adder that processes ChunkWidth bits per cycle through one narrow adder,
// holding the inter-chunk carry in a register; valid/ready on both sides.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter  int ChunkWidth = 8,
    parameter  int NumChunks  = 4,
    localparam int TotalWidth = total_width(ChunkWidth, NumChunks)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TotalWidth-1:0] in_a,
    input  logic [TotalWidth-1:0] in_b,
    input  logic                  in_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TotalWidth-1:0] out_sum,
    output logic                  out_c
);

    localparam int IdxW = $clog2(NumChunks);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

    state_t                state_reg, state_next;
    logic [IdxW-1:0]       idx_reg, idx_next;
    logic                  carry_reg, carry_next;
    logic [TotalWidth-1:0] a_sh_reg, a_sh_next;
    logic [TotalWidth-1:0] b_sh_reg, b_sh_next;
    logic [TotalWidth-1:0] sum_reg, sum_next;
    logic                  out_c_reg, out_c_next;
    logic                  load_chunk;

    logic [ChunkWidth-1:0] add_sum;
    logic                  add_c_out;

    // Operands shift right each BUSY cycle, so the current chunk is always the low slice.
    cr_adder #(
        .Width (ChunkWidth)
    ) u_cr_adder (
        .a     (a_sh_reg[ChunkWidth-1:0]),
        .b     (b_sh_reg[ChunkWidth-1:0]),
        .c_in  (carry_reg),
        .sum   (add_sum),
        .c_out (add_c_out)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        out_c_next = out_c_reg;
        load_chunk = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_sh_next  = in_a;
                    b_sh_next  = in_b;
                    carry_next = in_c;
                    idx_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                load_chunk = 1'b1;
                carry_next = add_c_out;
                a_sh_next  = a_sh_reg >> ChunkWidth;
                b_sh_next  = b_sh_reg >> ChunkWidth;
                if (idx_reg == LastIdx) begin
                    out_c_next = add_c_out;
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Only the chunk selected by idx is overwritten; the rest of the result holds.
    generate
        for (genvar gi = 0; gi < NumChunks; gi++) begin : g_chunk
            assign sum_next[gi*ChunkWidth +: ChunkWidth] =
                (load_chunk && (idx_reg == IdxW'(gi))) ? add_sum
                                                      : sum_reg[gi*ChunkWidth +: ChunkWidth];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            out_c_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            sum_reg   <= sum_next;
            out_c_reg <= out_c_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_sum   = sum_reg;
    assign out_c     = out_c_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (ChunkWidth=8, NumChunks=4):
// directed vector table, handshake corner cases, reset abort and a random stream.
module tb_seq_chunk_adder;

    localparam int CW = 8;
    localparam int NC = 4;
    localparam int TW = CW * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_a;
    logic [TW-1:0] in_b;
    logic          in_c;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_sum;
    logic          out_c;

    int n_checks = 0;
    int n_fail   = 0;

    seq_chunk_adder #(
        .ChunkWidth (CW),
        .NumChunks  (NC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          c;
        logic [TW-1:0] sum;
        logic          cout;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand, wait for its result and complete the output handshake.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                          output logic [TW-1:0] sum, output logic cout, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("wait_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        sum  = out_sum;
        cout = out_c;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    vec_t          vecs[6];
    logic [TW-1:0] r_sum;
    logic          r_c;
    int            lat;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};

        tick();
        tick();
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_sum",   64'(out_sum),   64'd0);
        chk("reset_out_c",     64'(out_c),     64'd0);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, r_sum, r_c, lat);
            chk($sformatf("vec%0d_sum", i),     64'(r_sum), 64'(vecs[i].sum));
            chk($sformatf("vec%0d_c", i),       64'(r_c),   64'(vecs[i].cout));
            chk($sformatf("vec%0d_latency", i), 64'(lat),   64'd4);
            $display("vec %0d: a=%h b=%h c=%0d -> sum=%h c=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].c, r_sum, r_c, lat);
        end

        // Back-pressure: result must hold while out_ready stays low
        in_valid = 1'b1; in_a = 32'h80000000; in_b = 32'h80000000; in_c = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 6; k++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_sum",   64'(out_sum),   64'd0);
            chk("bp_out_c",     64'(out_c),     64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready",  64'(in_ready),  64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
        $display("backpressure: sum=%h c=%0d held 6 cycles", 32'h0, 1'b1);

        // in_valid during BUSY/DONE is ignored until the next IDLE
        in_valid = 1'b1; in_a = 32'h000000FF; in_b = 32'h00000001; in_c = 1'b0;
        tick();
        in_a = 32'h12345678; in_b = 32'h11111111; in_c = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("busy_first_sum", 64'(out_sum), 64'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("busy_idle_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("busy_second_sum", 64'(out_sum), 64'h23456789);
        chk("busy_second_c",   64'(out_c),   64'd0);
        chk("busy_second_lat", 64'(lat),     64'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("busy_ignore: second op sum=%h", out_sum);

        // Reset mid-operation at idx=2 aborts and emits nothing
        in_valid = 1'b1; in_a = 32'hDEADBEEF; in_b = 32'h01010101; in_c = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_sum",   64'(out_sum),   64'd0);
        chk("abort_out_c",     64'(out_c),     64'd0);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) lat++;
            tick();
        end
        chk("abort_no_result", 64'(lat), 64'd0);
        $display("abort: in_ready=%0d out_valid=%0d", in_ready, out_valid);

        // Random stream with random handshakes against a 33-bit reference
        begin
            logic [TW:0] exp_q[$];
            logic [TW:0] ref_sum;
            logic [TW:0] got;
            int          sent;
            int          recv;
            int          cyc;
            logic        acc;
            logic        dlv;
            sent = 0;
            recv = 0;
            cyc  = 0;
            in_valid = 1'b0;
            while (recv < 1000 && cyc < 60000) begin
                if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_a     = $urandom();
                    in_b     = $urandom();
                    in_c     = 1'($urandom_range(0, 1));
                end
                out_ready = 1'($urandom_range(0, 1));
                acc = in_valid & in_ready;
                dlv = out_valid & out_ready;
                got = {out_c, out_sum};
                ref_sum = {1'b0, in_a} + {1'b0, in_b} + {{TW{1'b0}}, in_c};
                tick();
                cyc++;
                if (acc) begin
                    exp_q.push_back(ref_sum);
                    sent++;
                    in_valid = 1'b0;
                end
                if (dlv) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_spurious_result", 64'(got), 64'd0 - 64'd1);
                    end else begin
                        chk($sformatf("rand_result%0d", recv), 64'(got), 64'(exp_q.pop_front()));
                    end
                    recv++;
                end
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk("rand_result_count", 64'(recv), 64'd1000);
            chk("rand_queue_empty",  64'(exp_q.size()), 64'd0);
            $display("random: sent=%0d received=%0d cycles=%0d", sent, recv, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
